// File: rtl/ddr3_axi_pkg.sv
// Shared types and constants for the behavioural DDR3 AXI responder.
package ddr3_axi_pkg;

    // Transaction FSM: one burst in flight at a time.
    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DRAIN
    } state_t;

    // One AXI address unit is a DQ column; a beat carries a burst of 8 columns.
    localparam int BURST_SHIFT = 3;

    // Each DQ lane contributes 8 bits per beat (burst of 8).
    localparam int BITS_PER_DQ = 8;

    // Beat width in bits for a given DQ width.
    function automatic int beat_width(input int dq_width);
        return dq_width * BITS_PER_DQ;
    endfunction

endpackage

// File: rtl/bram_be_sp.sv
// Single-port RAM with per-byte write enables and a registered read port.
module bram_be_sp #(
    parameter int DEPTH_AW = 10,
    parameter int DATA_W   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_AW-1:0]   addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_AW];

    // Byte-enabled write into the array.
    // NOTE: the storage array has no reset; resetting it would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; the output register (not the array) clears on reset.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ddr3_axi_bram_slave.sv
// Behavioural stand-in for the DDR3 IP core: simplified Pango AXI slave
// backed by a byte-enabled on-chip RAM, with an emulated init-done flag.
module ddr3_axi_bram_slave
    import ddr3_axi_pkg::*;
#(
    parameter int          CTRL_ADDR_WIDTH = 28,
    parameter int          MEM_DQ_WIDTH    = 32,
    parameter int          DEPTH_AW        = 10,
    parameter logic [15:0] INIT_CYCLES     = 16'd200
) (
    input  logic                                core_clk,
    input  logic                                core_clk_rst_n,
    output logic                                ddr_init_done,

    input  logic [CTRL_ADDR_WIDTH-1:0]          axi_awaddr,
    input  logic [3:0]                          axi_awuser_id,
    input  logic                                axi_awuser_ap,
    input  logic [3:0]                          axi_awlen,
    input  logic                                axi_awvalid,
    output logic                                axi_awready,

    input  logic [MEM_DQ_WIDTH*BITS_PER_DQ-1:0] axi_wdata,
    input  logic [MEM_DQ_WIDTH-1:0]             axi_wstrb,
    output logic                                axi_wready,
    output logic [3:0]                          axi_wusero_id,
    output logic                                axi_wusero_last,

    input  logic [CTRL_ADDR_WIDTH-1:0]          axi_araddr,
    input  logic [3:0]                          axi_aruser_id,
    input  logic                                axi_aruser_ap,
    input  logic [3:0]                          axi_arlen,
    input  logic                                axi_arvalid,
    output logic                                axi_arready,

    output logic [MEM_DQ_WIDTH*BITS_PER_DQ-1:0] axi_rdata,
    output logic [3:0]                          axi_rid,
    output logic                                axi_rlast,
    output logic                                axi_rvalid
);

    localparam int BEAT_W = beat_width(MEM_DQ_WIDTH);

    state_t                state_q, state_d;
    logic [15:0]           init_cnt_q;
    logic                  init_done_q;
    logic                  prefer_rd_q;
    logic [DEPTH_AW-1:0]   idx_q;
    logic [3:0]            len_q;
    logic [3:0]            cnt_q;
    logic [3:0]            wr_id_q;
    logic [3:0]            rd_id_q;
    logic                  rvalid_q;
    logic                  rlast_q;

    logic                  aw_grant;
    logic                  ar_grant;
    logic                  beat_last;
    logic                  ram_en;
    logic                  ram_we;
    logic                  wlast;

    // Auto-precharge hints and address bits outside the index are deliberately dropped.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awuser_ap, axi_aruser_ap, axi_awaddr, axi_araddr};

    // Emulated calibration delay: count from reset release, then latch done.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            init_cnt_q <= init_cnt_q + 16'd1;
            if (init_cnt_q == INIT_CYCLES - 16'd1) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Arbitration, beat sequencing and RAM control for the current state.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        aw_grant  = 1'b0;
        ar_grant  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        wlast     = 1'b0;
        beat_last = (cnt_q == len_q);
        case (state_q)
            IDLE: begin
                if (init_done_q) begin
                    aw_grant = axi_awvalid && (!axi_arvalid || !prefer_rd_q);
                    ar_grant = axi_arvalid && (!axi_awvalid || prefer_rd_q);
                end
                if (aw_grant) begin
                    state_d = WR;
                end else if (ar_grant) begin
                    state_d = RD_ISSUE;
                end
            end
            WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                wlast  = beat_last;
                if (beat_last) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                ram_en = 1'b1;
                if (beat_last) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch burst parameters on a handshake, then step index and beat count.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wr_id_q     <= '0;
            rd_id_q     <= '0;
            prefer_rd_q <= 1'b0;
        end else if (aw_grant) begin
            idx_q       <= axi_awaddr[BURST_SHIFT +: DEPTH_AW];
            len_q       <= axi_awlen;
            wr_id_q     <= axi_awuser_id;
            cnt_q       <= '0;
            prefer_rd_q <= 1'b1;
        end else if (ar_grant) begin
            idx_q       <= axi_araddr[BURST_SHIFT +: DEPTH_AW];
            len_q       <= axi_arlen;
            rd_id_q     <= axi_aruser_id;
            cnt_q       <= '0;
            prefer_rd_q <= 1'b0;
        end else if (ram_en) begin
            idx_q <= idx_q + DEPTH_AW'(1);
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Read-valid pipeline aligned with the RAM's one-cycle read latency.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rvalid_q <= (state_q == RD_ISSUE);
            rlast_q  <= (state_q == RD_ISSUE) && beat_last;
        end
    end

    bram_be_sp #(
        .DEPTH_AW (DEPTH_AW),
        .DATA_W   (BEAT_W)
    ) u_ram (
        .clk   (core_clk),
        .rst_n (core_clk_rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (axi_wdata),
        .be    (axi_wstrb),
        .rdata (axi_rdata)
    );

    assign ddr_init_done   = init_done_q;
    assign axi_awready     = aw_grant;
    assign axi_arready     = ar_grant;
    assign axi_wready      = ram_we;
    assign axi_wusero_last = wlast;
    assign axi_wusero_id   = wr_id_q;
    assign axi_rvalid      = rvalid_q;
    assign axi_rlast       = rlast_q;
    assign axi_rid         = rd_id_q;

endmodule

// File: tb/tb_ddr3_axi_bram_slave.sv
// Self-checking bench for ddr3_axi_bram_slave: directed vector table,
// hand-written corner sequences and random traffic against a memory model.
module tb_ddr3_axi_bram_slave;

    localparam int AW    = 28;
    localparam int DQ    = 32;
    localparam int DAW   = 10;
    localparam int BW    = DQ * 8;
    localparam int NB    = DQ;
    localparam int DEPTH = 1 << DAW;

    typedef logic [BW-1:0] beat_t;

    typedef struct {
        bit              is_wr;
        logic [AW-1:0]   addr;
        logic [3:0]      id;
        beat_t           data;
        logic [NB-1:0]   strb;
        beat_t           exp;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            done;
    logic [AW-1:0]   awaddr;
    logic [3:0]      awid;
    logic            awap;
    logic [3:0]      awlen;
    logic            awvalid;
    logic            awready;
    beat_t           wdata;
    logic [NB-1:0]   wstrb;
    logic            wready;
    logic [3:0]      wid;
    logic            wlast;
    logic [AW-1:0]   araddr;
    logic [3:0]      arid;
    logic            arap;
    logic [3:0]      arlen;
    logic            arvalid;
    logic            arready;
    beat_t           rdata;
    logic [3:0]      rid;
    logic            rlast;
    logic            rvalid;

    ddr3_axi_bram_slave dut (
        .core_clk        (clk),
        .core_clk_rst_n  (rst_n),
        .ddr_init_done   (done),
        .axi_awaddr      (awaddr),
        .axi_awuser_id   (awid),
        .axi_awuser_ap   (awap),
        .axi_awlen       (awlen),
        .axi_awvalid     (awvalid),
        .axi_awready     (awready),
        .axi_wdata       (wdata),
        .axi_wstrb       (wstrb),
        .axi_wready      (wready),
        .axi_wusero_id   (wid),
        .axi_wusero_last (wlast),
        .axi_araddr      (araddr),
        .axi_aruser_id   (arid),
        .axi_aruser_ap   (arap),
        .axi_arlen       (arlen),
        .axi_arvalid     (arvalid),
        .axi_arready     (arready),
        .axi_rdata       (rdata),
        .axi_rid         (rid),
        .axi_rlast       (rlast),
        .axi_rvalid      (rvalid)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t model [DEPTH];
    beat_t wbuf [16];
    logic [NB-1:0] sbuf [16];
    beat_t rbuf [16];
    int    hs_wait;
    vec_t  vecs [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input beat_t got, input beat_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    function automatic beat_t merge(input beat_t old, input beat_t d, input logic [NB-1:0] s);
        beat_t r = old;
        for (int i = 0; i < NB; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t r;
        for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [AW-1:0] mk_addr(input int idx);
        logic [AW-1:0] hi = AW'($urandom() % (1 << (AW - DAW - 3)));
        return (hi << (DAW + 3)) | AW'(idx << 3) | AW'($urandom() % 8);
    endfunction

    // Write burst using wbuf/sbuf; updates the model on each accepted beat.
    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] len,
                            input logic [3:0] id, input int budget);
        int base = idx_of(a);
        bit ok = 0;
        awaddr = a; awlen = len; awid = id; awap = 1'($urandom()); awvalid = 1'b1;
        hs_wait = 0;
        forever begin
            #1;
            if (awready) begin ok = 1; break; end
            if (hs_wait >= budget) break;
            next_cyc();
            hs_wait++;
        end
        if (!ok) begin
            check("aw_handshake_timeout", beat_t'(0), beat_t'(1));
            awvalid = 1'b0;
            next_cyc();
            return;
        end
        next_cyc();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b];
            #1;
            check("wready", beat_t'(wready), beat_t'(1));
            check("wusero_last", beat_t'(wlast), beat_t'(b == int'(len)));
            check("wusero_id", beat_t'(wid), beat_t'(id));
            if (wready) model[(base + b) % DEPTH] = merge(model[(base + b) % DEPTH], wbuf[b], sbuf[b]);
            next_cyc();
        end
        #1;
        check("wready_after_burst", beat_t'(wready), beat_t'(0));
        next_cyc();
    endtask

    // Read burst; checks timing, ID, last and data against the model; fills rbuf.
    task automatic do_read(input logic [AW-1:0] a, input logic [3:0] len,
                           input logic [3:0] id, input int budget);
        int base = idx_of(a);
        bit ok = 0;
        araddr = a; arlen = len; arid = id; arap = 1'($urandom()); arvalid = 1'b1;
        hs_wait = 0;
        forever begin
            #1;
            if (arready) begin ok = 1; break; end
            if (hs_wait >= budget) break;
            next_cyc();
            hs_wait++;
        end
        if (!ok) begin
            check("ar_handshake_timeout", beat_t'(0), beat_t'(1));
            arvalid = 1'b0;
            next_cyc();
            return;
        end
        next_cyc();
        arvalid = 1'b0;
        #1;
        check("rvalid_issue_gap", beat_t'(rvalid), beat_t'(0));
        next_cyc();
        for (int b = 0; b <= int'(len); b++) begin
            #1;
            check("rvalid", beat_t'(rvalid), beat_t'(1));
            check("rlast", beat_t'(rlast), beat_t'(b == int'(len)));
            check("rid", beat_t'(rid), beat_t'(id));
            check("rdata_model", rdata, model[(base + b) % DEPTH]);
            rbuf[b] = rdata;
            next_cyc();
        end
        #1;
        check("rvalid_after_burst", beat_t'(rvalid), beat_t'(0));
        next_cyc();
    endtask

    initial begin
        beat_t d;
        bit    ok;
        awaddr = '0; awid = '0; awap = 1'b0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0;
        araddr = '0; arid = '0; arap = 1'b0; arlen = '0; arvalid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state: every output low.
        check("reset_ctrl_outputs",
              beat_t'({done, awready, arready, wready, wlast, wid, rvalid, rlast, rid}), beat_t'(0));
        check("reset_rdata", rdata, beat_t'(0));

        // Init: awvalid held from reset release; grant must appear exactly at cycle 200.
        rst_n = 1'b1;
        wbuf[0] = rand_beat(); sbuf[0] = '1;
        do_write(AW'(5 << 3), 4'd0, 4'd7, 300);
        check("init_handshake_cycle", beat_t'(hs_wait), beat_t'(200));
        check("init_done_after_200", beat_t'(done), beat_t'(1));

        // Fill the whole RAM with 16-beat bursts so every later read is defined.
        for (int i = 0; i < DEPTH / 16; i++) begin
            for (int b = 0; b < 16; b++) begin wbuf[b] = rand_beat(); sbuf[b] = '1; end
            do_write(mk_addr(i * 16), 4'd15, 4'(i), 40);
        end

        // 16-beat incrementing burst and readback.
        for (int b = 0; b < 16; b++) begin wbuf[b] = {8{32'(b + 1)}}; sbuf[b] = '1; end
        do_write(AW'(100 << 3), 4'd15, 4'd2, 20);
        do_read(AW'(100 << 3), 4'd15, 4'd6, 20);
        for (int b = 0; b < 16; b++) check($sformatf("burst16_beat%0d", b), rbuf[b], {8{32'(b + 1)}});

        // Directed vectors: single beat, byte strobes, address aliasing.
        d = '1;
        vecs[0] = '{1'b1, 28'h0000008, 4'd3, {32{8'hA5}}, '1,       '0};
        vecs[1] = '{1'b0, 28'h0000008, 4'd9, '0,           '0,       {32{8'hA5}}};
        vecs[2] = '{1'b1, 28'h0000008, 4'd4, d,            '1,       '0};
        vecs[3] = '{1'b1, 28'h0000008, 4'd5, '0,           32'h0000_000F, '0};
        vecs[4] = '{1'b0, 28'h0000008, 4'd1, '0,           '0,       {d[BW-1:32], 32'h0}};
        vecs[5] = '{1'b0, 28'h0002008, 4'd2, '0,           '0,       {d[BW-1:32], 32'h0}};
        vecs[6] = '{1'b0, 28'h000000F, 4'd3, '0,           '0,       {d[BW-1:32], 32'h0}};
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_wr) begin
                wbuf[0] = vecs[i].data; sbuf[0] = vecs[i].strb;
                do_write(vecs[i].addr, 4'd0, vecs[i].id, 20);
            end else begin
                do_read(vecs[i].addr, 4'd0, vecs[i].id, 20);
                check($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp);
            end
        end

        // Wrap: 4 beats from index 1022 land at 1022, 1023, 0, 1.
        for (int b = 0; b < 4; b++) begin wbuf[b] = rand_beat(); sbuf[b] = '1; end
        do_write(AW'((DEPTH - 2) << 3), 4'd3, 4'd8, 20);
        do_read(AW'(0), 4'd0, 4'd1, 20);
        check("wrap_idx0", rbuf[0], wbuf[2]);
        do_read(AW'(1 << 3), 4'd0, 4'd1, 20);
        check("wrap_idx1", rbuf[0], wbuf[3]);
        do_read(AW'((DEPTH - 2) << 3), 4'd3, 4'd2, 20);
        for (int b = 0; b < 4; b++) check($sformatf("wrap_read_beat%0d", b), rbuf[b], wbuf[b]);

        // Simultaneous valids: write first, then read, then write again.
        d = rand_beat();
        awaddr = AW'(200 << 3); awlen = 4'd0; awid = 4'd11;
        araddr = AW'(200 << 3); arlen = 4'd0; arid = 4'd12;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("both_valid_first_aw", beat_t'({awready, arready}), beat_t'(2'b10));
        next_cyc();
        wdata = d; wstrb = '1;
        #1;
        check("both_valid_wr_beat", beat_t'({wready, awready, arready}), beat_t'(3'b100));
        if (wready) model[200] = d;
        next_cyc();
        #1;
        check("both_valid_second_ar", beat_t'({awready, arready}), beat_t'(2'b01));
        next_cyc();
        arvalid = 1'b0;
        #1;
        check("both_valid_third_aw", beat_t'({awready, arready}), beat_t'(2'b00));
        next_cyc();
        #1;
        check("raw_rvalid", beat_t'({rvalid, rlast, rid}), beat_t'({2'b11, 4'd12}));
        check("raw_rdata", rdata, d);
        next_cyc();
        #1;
        check("third_grant_aw", beat_t'({awready, arready}), beat_t'(2'b10));
        next_cyc();
        awvalid = 1'b0;
        wbuf[0] = rand_beat();
        wdata = wbuf[0];
        #1;
        check("third_wr_beat", beat_t'(wready), beat_t'(1));
        if (wready) model[200] = wbuf[0];
        next_cyc();

        // Random traffic with aliased addresses, random lengths and strobes.
        for (int n = 0; n < 60; n++) begin
            int idx = int'($urandom() % DEPTH);
            logic [3:0] len = 4'($urandom());
            if ($urandom() % 2 == 0) begin
                for (int b = 0; b < 16; b++) begin wbuf[b] = rand_beat(); sbuf[b] = NB'($urandom()); end
                do_write(mk_addr(idx), len, 4'($urandom()), 20);
            end else begin
                do_read(mk_addr(idx), len, 4'($urandom()), 20);
            end
        end
        check("init_done_held", beat_t'(done), beat_t'(1));

        // Reset mid-write: beats stop at once; pointer returns to write-first.
        for (int b = 0; b < 16; b++) begin wbuf[b] = rand_beat(); sbuf[b] = '1; end
        awaddr = AW'(300 << 3); awlen = 4'd15; awid = 4'd3; awvalid = 1'b1;
        #1;
        check("abort_wr_grant", beat_t'(awready), beat_t'(1));
        next_cyc();
        awvalid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b];
            #1;
            if (wready) model[(300 + b) % DEPTH] = wbuf[b];
            next_cyc();
        end
        rst_n = 1'b0;
        #1;
        check("abort_wr_reset", beat_t'({wready, wlast, done}), beat_t'(0));
        next_cyc();
        #1;
        check("abort_wr_next_cycle", beat_t'(wready), beat_t'(0));
        next_cyc();
        rst_n = 1'b1;
        awaddr = AW'(310 << 3); awlen = 4'd0; awid = 4'd4; awvalid = 1'b1;
        araddr = AW'(300 << 3); arlen = 4'd0; arid = 4'd5; arvalid = 1'b1;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (awready || arready) begin ok = 1; break; end
            next_cyc();
        end
        check("grant_seen_after_reset", beat_t'(ok), beat_t'(1));
        check("grant_after_reset_is_aw", beat_t'({awready, arready}), beat_t'(2'b10));
        next_cyc();
        awvalid = 1'b0; arvalid = 1'b0;
        wbuf[0] = rand_beat(); wdata = wbuf[0]; wstrb = '1;
        #1;
        if (wready) model[310] = wbuf[0];
        next_cyc();
        next_cyc();
        do_read(AW'(300 << 3), 4'd11, 4'd6, 20);

        // Reset mid-read: rvalid drops immediately and stays low.
        araddr = AW'(0); arlen = 4'd15; arid = 4'd9; arvalid = 1'b1;
        #1;
        check("abort_rd_grant", beat_t'(arready), beat_t'(1));
        next_cyc();
        arvalid = 1'b0;
        next_cyc();
        #1;
        check("abort_rd_beat0", beat_t'(rvalid), beat_t'(1));
        next_cyc();
        #1;
        check("abort_rd_beat1", beat_t'(rvalid), beat_t'(1));
        next_cyc();
        rst_n = 1'b0;
        #1;
        check("abort_rd_reset", beat_t'({rvalid, rlast, rid}), beat_t'(0));
        next_cyc();
        #1;
        check("abort_rd_next_cycle", beat_t'(rvalid), beat_t'(0));
        check("abort_rd_rdata", rdata, beat_t'(0));
        next_cyc();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
